// File: rtl/clock_period_meter.sv
// clock_period_meter
//
// Measures the high time, low time and period of a slow, asynchronous
// clock-like signal (meas_clk) in clk_in cycles. It also reports when two
// consecutive periods agree within +/-1 cycle (locked) and when the input
// has stopped toggling (timeout, sticky).
//
// Ports
//   clk_in         system clock; all state changes on its rising edge
//   reset_n        synchronous reset, active-low
//   meas_clk       measured signal, asynchronous to clk_in
//   enable         measurement enable; dropping it parks the meter in IDLE
//   high_cycles    last published high time
//   low_cycles     last published low time
//   period_cycles  high_cycles + low_cycles at full width
//   valid          one-cycle pulse when new results are published
//   locked         the last two published periods differ by at most 1
//   timeout        no edge seen for TIMEOUT cycles; cleared by the next
//                  publish, by reset or by re-enabling
module clock_period_meter #(
  parameter int CNT_WIDTH = 10,
  parameter int TIMEOUT   = 1000
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic                 meas_clk,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] high_cycles,
  output logic [CNT_WIDTH-1:0] low_cycles,
  output logic [CNT_WIDTH:0]   period_cycles,
  output logic                 valid,
  output logic                 locked,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]   LOCK_TOL = (CNT_WIDTH + 1)'(1);

  typedef enum logic [1:0] {IDLE, SEEK, HIGH, LOW} state_t;

  state_t               state;
  logic                 s1;
  logic                 s2;
  logic                 s3;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] h_tmp;
  logic [CNT_WIDTH:0]   prev_period;
  logic [CNT_WIDTH:0]   new_period;
  logic                 rise;
  logic                 fall;
  logic                 any_edge;
  logic                 lost;

  // Counter step that sticks at the loss-of-signal threshold.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_ONE;
  endfunction

  // Larger minus smaller, so the difference never wraps.
  function automatic logic [CNT_WIDTH:0] abs_diff(input logic [CNT_WIDTH:0] a,
                                                  input logic [CNT_WIDTH:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // ---- edge detect on synchronized input (s2 = current, s3 = history) ----
  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign any_edge = rise | fall;

  // An edge arriving in the same cycle as the threshold wins over timeout.
  assign lost = (state != IDLE) && !any_edge && (cnt == CNT_MAX);

  // Full-width sum: both halves can be at their maximum at once.
  assign new_period = {1'b0, h_tmp} + {1'b0, cnt};

  // ---- synchronizer / counter / FSM / registered results ----
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      s3            <= 1'b0;
      state         <= IDLE;
      cnt           <= '0;
      h_tmp         <= '0;
      prev_period   <= '0;
      high_cycles   <= '0;
      low_cycles    <= '0;
      period_cycles <= '0;
      valid         <= 1'b0;
      locked        <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      s1    <= meas_clk;
      s2    <= s1;
      s3    <= s2;
      valid <= 1'b0;

      if (!enable) begin
        // Results and timeout hold; a zero prev_period means "no reference".
        state       <= IDLE;
        cnt         <= '0;
        locked      <= 1'b0;
        prev_period <= '0;
      end else begin
        if (state == IDLE) begin
          cnt <= '0;
        end else if (any_edge) begin
          cnt <= CNT_ONE;
        end else begin
          cnt <= sat_inc(cnt);
        end

        if (lost) begin
          state       <= SEEK;
          timeout     <= 1'b1;
          locked      <= 1'b0;
          prev_period <= '0;
        end else begin
          case (state)
            IDLE: begin
              // Only reached after reset or enable low, so this is the
              // rising edge of enable.
              state   <= SEEK;
              timeout <= 1'b0;
            end
            SEEK: begin
              if (rise) state <= HIGH;
            end
            HIGH: begin
              if (fall) begin
                h_tmp <= cnt;
                state <= LOW;
              end
            end
            LOW: begin
              if (rise) begin
                high_cycles   <= h_tmp;
                low_cycles    <= cnt;
                period_cycles <= new_period;
                valid         <= 1'b1;
                timeout       <= 1'b0;
                // Any real period is at least 2, so zero never locks.
                locked        <= (prev_period != '0) &&
                                 (abs_diff(new_period, prev_period) <= LOCK_TOL);
                prev_period   <= new_period;
                state         <= HIGH;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Testbench for clock_period_meter: drives meas_clk waveforms with exact
// phase lengths, predicts every publish into a scoreboard queue and compares
// each valid pulse against the head of that queue.
module tb_clock_period_meter;

  localparam int CW = 10;
  localparam int TO = 1000;

  logic          clk_in;
  logic          reset_n;
  logic          meas_clk;
  logic          enable;
  logic [CW-1:0] high_cycles;
  logic [CW-1:0] low_cycles;
  logic [CW:0]   period_cycles;
  logic          valid;
  logic          locked;
  logic          timeout;

  clock_period_meter #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk_in        (clk_in),
    .reset_n       (reset_n),
    .meas_clk      (meas_clk),
    .enable        (enable),
    .high_cycles   (high_cycles),
    .low_cycles    (low_cycles),
    .period_cycles (period_cycles),
    .valid         (valid),
    .locked        (locked),
    .timeout       (timeout)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    int h;
    int l;
    int p;
    int lk;
    int gap;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_vld_cyc = 0;

  // Waveform model state
  int ph = 0;
  int pl = 0;
  bit have_pend = 1'b0;
  bit prev_ok   = 1'b0;
  int prev_p    = 0;
  int last_h    = 0;
  int last_l    = 0;
  int last_p    = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // A rise ends the previous full period, which the meter then publishes.
  task automatic model_on_rise();
    exp_t e;
    int   d;
    if (have_pend) begin
      e.h   = ph;
      e.l   = pl;
      e.p   = ph + pl;
      d     = (e.p > prev_p) ? e.p - prev_p : prev_p - e.p;
      e.lk  = (prev_ok && d <= 1) ? 1 : 0;
      e.gap = prev_ok ? e.p : 0;
      sb.push_back(e);
      prev_ok = 1'b1;
      prev_p  = e.p;
      last_h  = e.h;
      last_l  = e.l;
      last_p  = e.p;
    end
    have_pend = 1'b0;
  endtask

  task automatic model_reset();
    have_pend = 1'b0;
    prev_ok   = 1'b0;
    prev_p    = 0;
  endtask

  task automatic drive_period(input int h, input int l);
    model_on_rise();
    meas_clk = 1'b1;
    repeat (h) @(negedge clk_in);
    meas_clk = 1'b0;
    repeat (l) @(negedge clk_in);
    ph = h;
    pl = l;
    have_pend = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_high"},   high_cycles,   0);
    check({tag, "_low"},    low_cycles,    0);
    check({tag, "_period"}, period_cycles, 0);
    check({tag, "_valid"},  valid,         0);
    check({tag, "_locked"}, locked,        0);
    check({tag, "_timeout"}, timeout,      0);
  endtask

  task automatic check_held(input string tag);
    check({tag, "_high"},   high_cycles,   last_h);
    check({tag, "_low"},    low_cycles,    last_l);
    check({tag, "_period"}, period_cycles, last_p);
  endtask

  // Scoreboard consumer: every valid pulse must match the next prediction.
  always @(negedge clk_in) begin
    cyc++;
    if (valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("pub_high",    high_cycles,   mon_e.h);
        check("pub_low",     low_cycles,    mon_e.l);
        check("pub_period",  period_cycles, mon_e.p);
        check("pub_locked",  locked,        mon_e.lk);
        check("pub_timeout", timeout,       0);
        if (mon_e.gap != 0) check("valid_gap", cyc - last_vld_cyc, mon_e.gap);
      end
      last_vld_cyc = cyc;
    end
  end

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    meas_clk = 1'b0;
    repeat (3) @(negedge clk_in);
    check_all_zero("reset");
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (5) @(negedge clk_in);

    // Square wave 5/5
    for (int i = 0; i < 4; i++) drive_period(5, 5);

    // Duty change 3/7, then frequency change 10/10
    for (int i = 0; i < 3; i++) drive_period(3, 7);
    for (int i = 0; i < 2; i++) drive_period(10, 10);

    // Stuck high: the rise publishes the last 10/10 period, then silence
    model_on_rise();
    meas_clk = 1'b1;
    repeat (2 + TO) @(negedge clk_in);
    check("timeout_early", timeout, 0);
    @(negedge clk_in);
    check("timeout_set", timeout, 1);
    check("timeout_unlock", locked, 0);
    check_held("timeout_hold");
    model_reset();
    meas_clk = 1'b0;
    repeat (5) @(negedge clk_in);
    check("timeout_sticky", timeout, 1);
    for (int i = 0; i < 3; i++) drive_period(5, 5);

    // Enable drop in the middle of a high phase
    model_on_rise();
    meas_clk = 1'b1;
    repeat (4) @(negedge clk_in);
    enable = 1'b0;
    model_reset();
    @(negedge clk_in);
    check("endrop_locked", locked, 0);
    check("endrop_valid", valid, 0);
    repeat (3) @(negedge clk_in);
    meas_clk = 1'b0;
    repeat (4) @(negedge clk_in);
    meas_clk = 1'b1;
    repeat (4) @(negedge clk_in);
    meas_clk = 1'b0;
    repeat (6) @(negedge clk_in);
    check_held("endrop_hold");
    check("endrop_timeout", timeout, 0);
    enable = 1'b1;
    repeat (5) @(negedge clk_in);
    for (int i = 0; i < 2; i++) drive_period(5, 5);

    // Reset during a low phase
    model_on_rise();
    meas_clk = 1'b1;
    repeat (5) @(negedge clk_in);
    meas_clk = 1'b0;
    repeat (6) @(negedge clk_in);
    reset_n = 1'b0;
    @(negedge clk_in);
    check_all_zero("midreset");
    reset_n = 1'b1;
    model_reset();
    repeat (6) @(negedge clk_in);
    check("midreset_novalid", period_cycles, 0);

    // Minimum phases, then a phase exactly TIMEOUT long
    for (int i = 0; i < 3; i++) drive_period(2, 2);
    drive_period(TO, 5);
    check("edge_at_limit_no_timeout", timeout, 0);
    for (int i = 0; i < 2; i++) drive_period(5, 5);
    model_on_rise();
    meas_clk = 1'b1;
    repeat (6) @(negedge clk_in);
    meas_clk = 1'b0;
    repeat (5) @(negedge clk_in);

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures the waveform of a slow, asynchronous clock-like input in `clk_in` cycles and reports high time, low time, period, lock and loss-of-signal status. It is the receiving end of the LED controller's divided clocks: it recovers timing from a divided clock so that divider settings and LED refresh rates can be checked in-system. It sits in the `clk_in` domain beside the dividers and feeds status and debug logic.

## Interface
- `CNT_WIDTH`, default 10: width of the high/low counters and results.
- `TIMEOUT`, default 1000: cycles without an edge before loss of signal. Must satisfy `2 ≤ TIMEOUT ≤ 2^CNT_WIDTH − 1`.

- `clk_in`  in  1  system clock; all state updates on its rising edge.
- `reset_n`  in  1  reset, synchronous to `clk_in`, active-low.
- `meas_clk`  in  1  measured signal, asynchronous to `clk_in`.
- `enable`  in  1  measurement enable.
- `high_cycles`  out  CNT_WIDTH  last measured high time.
- `low_cycles`  out  CNT_WIDTH  last measured low time.
- `period_cycles`  out  CNT_WIDTH+1  `high_cycles + low_cycles`, with no overflow.
- `valid`  out  1  one-cycle pulse when a new result is published.
- `locked`  out  1  two consecutive periods agree within ±1.
- `timeout`  out  1  loss of signal; sticky.

## Operation
- **Input path**
  - `meas_clk` passes through a 2-flop synchronizer into `s2`, then into history flop `s3`.
  - Rise = `s2 & ~s3`. Fall = `~s2 & s3`.
- **Counter `cnt`**
  - Loads 1 on any rise or fall.
  - Otherwise increments by 1 and saturates at `TIMEOUT`.
  - A half-period of N stable `clk_in` cycles therefore measures as N.
- **State machine**
  - IDLE:
    - Entered on reset or `enable=0`.
    - `cnt` held at 0.
    - Leaves to SEEK when `enable=1`.
  - SEEK:
    - Waits for a rise, then goes to HIGH.
    - The partial first phase is never published.
  - HIGH:
    - On a fall, latch `cnt` into internal `h_tmp` and go to LOW.
  - LOW:
    - On a rise, load `high_cycles=h_tmp`, `low_cycles=cnt`, `period_cycles=h_tmp+cnt`.
    - Pulse `valid`, then go to HIGH.
  - SEEK, HIGH or LOW with no edge while `cnt==TIMEOUT`:
    - Set `timeout=1`, clear `locked`, go to SEEK.
    - Result outputs hold their values.
  - `enable=0` in any state:
    - Go to IDLE next cycle and clear `locked`.
    - Results and `timeout` hold; no `valid` is generated.
    - `enable` has priority over edges and timeout in the same cycle.
- **Lock**
  - On each publish, compare the new period with the previous published period (`prev_period`).
  - |diff| ≤ 1 sets `locked`; otherwise `locked` clears.
  - `prev_period` is invalidated by reset, timeout or IDLE, so the first publish after any of these leaves `locked=0`.
- **`timeout` clearing**
  - Cleared by the next publish (`valid`), by reset, or by `enable` rising from 0.
- **Input constraint**
  - High and low phases must be ≥2 `clk_in` cycles.
  - Shorter glitches may be missed; the FSM must never stall or leave a legal state.
- **Reset values**
  - `high_cycles=0`, `low_cycles=0`, `period_cycles=0`.
  - `valid=0`, `locked=0`, `timeout=0`.
  - State IDLE; synchronizer flops, `cnt`, `h_tmp` and `prev_period` all 0.
  - `reset_n` low mid-measurement aborts it; nothing is published.

## Timing
- **Edge latency:** a `meas_clk` transition is detected 2–3 `clk_in` rising edges later, depending on metastability resolution and phase.
- **Publish latency:** `valid` and the new results are registered and visible in the cycle after the rise-detect cycle.
  - They are stable until the next publish.
- **Lock latency:** `locked` updates in the same cycle as `valid`.
- **Timeout latency:** `timeout` asserts the cycle after `cnt` reaches `TIMEOUT`, i.e. `TIMEOUT+1` cycles after the last detected edge.
- **Throughput:** first `valid` comes after 1 rise + 1 full period. After that there is one `valid` per input period, with no dead cycles.
- **Arithmetic:**
  - `period_cycles` is computed at full CNT_WIDTH+1 width.
  - The lock comparison uses unsigned subtraction of the larger minus the smaller period.

## Test plan
- **Square wave:** `enable=1`, `meas_clk` 5 high / 5 low. Expect the first `valid` with high=5, low=5, period=10 and `locked=0`. The second `valid` has `locked=1`, and `valid` then repeats every 10 cycles.
- **Duty and frequency change:**
  - 3 high / 7 low gives high=3, low=7, period=10.
  - Switching to 10/10 gives `valid` with period=20 and `locked=0`.
  - The next `valid` gives `locked=1`.
- **Stuck input:** `meas_clk` held high after lock. Expect `timeout=1` and `locked=0` 1001 cycles after the last edge, results held, state SEEK. Restarting a 5/5 wave clears `timeout` at the next `valid`.
- **Enable drop:** `enable=0` mid-HIGH. Expect IDLE next cycle, `locked=0`, no `valid`, results unchanged. Re-enabling requires a rise plus a full period before the next `valid`.
- **Reset mid-LOW:** assert `reset_n=0` for one cycle. All outputs are 0 the cycle after and no `valid` is produced. Measurement resumes from SEEK.
- **Boundary:** a 2/2 wave gives high=2, low=2, period=4, `locked` on the second result. An edge in the same cycle that `cnt` hits `TIMEOUT` takes the edge, with no timeout.
